// File: rtl/match_sequencer.sv
// match_sequencer
// Match flow controller for the pong game: title screen, serve hold, rally,
// post-point pause, game over. Scores are kept as packed BCD for the display.
// Frame timing comes from rising edges of the VGA vertical sync.
// Build option: define MATCH_PAUSE_EN to add the PAUSE state (P key toggles).
module match_sequencer #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_vs,
    input  logic [31:0] keycode,
    input  logic        point_p1,
    input  logic        point_p2,
    output logic        ball_hold,
    output logic        run,
    output logic        serve_dir,
    output logic [7:0]  score1,
    output logic [7:0]  score2,
    output logic [1:0]  Display,
    output logic        winner
);

    localparam logic [7:0] KEY_START  = 8'h2C;
    localparam logic [7:0] WIN_BCD    = 8'(((WIN_SCORE / 10) % 10) * 16 + (WIN_SCORE % 10));
    localparam logic [7:0] SERVE_CNT  = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_CNT  = 8'(POINT_FRAMES);
    localparam logic [1:0] DISP_TITLE = 2'd0;
    localparam logic [1:0] DISP_PLAY  = 2'd1;
    localparam logic [1:0] DISP_OVER  = 2'd2;

`ifdef MATCH_PAUSE_EN
    localparam logic [7:0] KEY_PAUSE  = 8'h13;
    localparam logic [1:0] DISP_PAUSE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_RALLY, S_POINT, S_OVER, S_PAUSE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_RALLY, S_POINT, S_OVER
    } state_t;
`endif

    // True when any of the four HID key slots holds the given code.
    function automatic logic key_present(input logic [31:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < 4; b++)
            if (kc[8*b +: 8] == code) hit = 1'b1;
        return hit;
    endfunction

    // Packed-BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] res;
        if (v == 8'h99)
            res = v;
        else if (v[3:0] == 4'd9)
            res = {v[7:4] + 4'd1, 4'd0};
        else
            res = {v[7:4], v[3:0] + 4'd1};
        return res;
    endfunction

    logic       r_vs_s1, r_vs_s2, r_vs_d;
    logic       w_tick;
    logic       w_start_now, r_start_prev, r_start_arm, w_start_press;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_ball_hold, r_run, r_serve_dir, r_winner;
    logic [7:0] r_score1, r_score2;
    logic [1:0] r_display;

`ifdef MATCH_PAUSE_EN
    logic       w_pause_now, r_pause_prev, r_pause_arm, w_pause_press;
    state_t     r_save_state;
    logic [7:0] r_save_cnt;
`endif

    // Bring vsync into the Clk domain and keep one older sample for edge detect.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_d  <= 1'b0;
        end else begin
            r_vs_s1 <= frame_vs;
            r_vs_s2 <= r_vs_s1;
            r_vs_d  <= r_vs_s2;
        end
    end

    assign w_tick      = r_vs_s2 & ~r_vs_d;
    assign w_start_now = key_present(keycode, KEY_START);
    // The arm bit only sets once the key has been seen released, so a key
    // held through reset never counts as a fresh press.
    assign w_start_press = w_start_now & ~r_start_prev & r_start_arm;

`ifdef MATCH_PAUSE_EN
    assign w_pause_now   = key_present(keycode, KEY_PAUSE);
    assign w_pause_press = w_pause_now & ~r_pause_prev & r_pause_arm;
`endif

    // Key history for press edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_start_prev <= 1'b0;
            r_start_arm  <= 1'b0;
`ifdef MATCH_PAUSE_EN
            r_pause_prev <= 1'b0;
            r_pause_arm  <= 1'b0;
`endif
        end else begin
            r_start_prev <= w_start_now;
            if (!w_start_now) r_start_arm <= 1'b1;
`ifdef MATCH_PAUSE_EN
            r_pause_prev <= w_pause_now;
            if (!w_pause_now) r_pause_arm <= 1'b1;
`endif
        end
    end

    // Match state machine; every output is updated together with the state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ball_hold <= 1'b1;
            r_run       <= 1'b0;
            r_serve_dir <= 1'b1;
            r_score1    <= '0;
            r_score2    <= '0;
            r_display   <= DISP_TITLE;
            r_winner    <= 1'b0;
`ifdef MATCH_PAUSE_EN
            r_save_state <= S_IDLE;
            r_save_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_press) begin
                        r_score1    <= '0;
                        r_score2    <= '0;
                        r_serve_dir <= 1'b1;
                        r_state     <= S_SERVE;
                        r_cnt       <= SERVE_CNT;
                        r_display   <= DISP_PLAY;
                        r_ball_hold <= 1'b1;
                        r_run       <= 1'b1;
                    end
                end
                S_SERVE: begin
`ifdef MATCH_PAUSE_EN
                    if (w_pause_press) begin
                        r_save_state <= S_SERVE;
                        r_save_cnt   <= r_cnt;
                        r_state      <= S_PAUSE;
                        r_display    <= DISP_PAUSE;
                        r_run        <= 1'b0;
                    end else
`endif
                    if (w_tick) begin
                        // The tick that takes the count to zero releases the ball.
                        if (r_cnt <= 8'd1) begin
                            r_cnt       <= '0;
                            r_state     <= S_RALLY;
                            r_ball_hold <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                S_RALLY: begin
                    // A point beats a simultaneous pause press so no point is lost.
                    if (point_p1 || point_p2) begin
                        if (point_p1 && !point_p2) begin
                            r_score1    <= bcd_inc(r_score1);
                            r_serve_dir <= 1'b1;
                        end else if (point_p2 && !point_p1) begin
                            r_score2    <= bcd_inc(r_score2);
                            r_serve_dir <= 1'b0;
                        end
                        r_state     <= S_POINT;
                        r_cnt       <= POINT_CNT;
                        r_ball_hold <= 1'b1;
                        r_run       <= 1'b0;
                    end
`ifdef MATCH_PAUSE_EN
                    else if (w_pause_press) begin
                        r_save_state <= S_RALLY;
                        r_save_cnt   <= r_cnt;
                        r_state      <= S_PAUSE;
                        r_display    <= DISP_PAUSE;
                        r_run        <= 1'b0;
                    end
`endif
                end
                S_POINT: begin
                    if (w_tick) begin
                        if (r_cnt <= 8'd1) begin
                            r_cnt <= '0;
                            if (r_score1 == WIN_BCD || r_score2 == WIN_BCD) begin
                                r_state   <= S_OVER;
                                r_display <= DISP_OVER;
                                r_winner  <= (r_score1 == WIN_BCD) ? 1'b0 : 1'b1;
                            end else begin
                                r_state <= S_SERVE;
                                r_cnt   <= SERVE_CNT;
                                r_run   <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                S_OVER: begin
                    if (w_start_press) begin
                        r_score1    <= '0;
                        r_score2    <= '0;
                        r_serve_dir <= ~r_winner;
                        r_state     <= S_SERVE;
                        r_cnt       <= SERVE_CNT;
                        r_display   <= DISP_PLAY;
                        r_ball_hold <= 1'b1;
                        r_run       <= 1'b1;
                    end
                end
`ifdef MATCH_PAUSE_EN
                S_PAUSE: begin
                    // ball_hold was left as it was on entry, so only the
                    // play display and motion enable need restoring.
                    if (w_pause_press) begin
                        r_state   <= r_save_state;
                        r_cnt     <= r_save_cnt;
                        r_display <= DISP_PLAY;
                        r_run     <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_ball_hold <= 1'b1;
                    r_run       <= 1'b0;
                    r_display   <= DISP_TITLE;
                end
            endcase
        end
    end

    assign ball_hold = r_ball_hold;
    assign run       = r_run;
    assign serve_dir = r_serve_dir;
    assign score1    = r_score1;
    assign score2    = r_score2;
    assign Display   = r_display;
    assign winner    = r_winner;

endmodule

// File: tb/tb_match_sequencer.sv
// Testbench for match_sequencer: directed match scenarios plus randomized
// keys, point pulses and resets, all checked every cycle against a
// behavioural model of the match rules.
`timescale 1ns/1ps
module tb_match_sequencer;

    localparam int WIN = 11;
    localparam int SF  = 60;
    localparam int PF  = 90;
`ifdef MATCH_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_SERVE = 1, P_RALLY = 2, P_POINT = 3, P_OVER = 4, P_PAUSE = 5;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_vs = 1'b0;
    logic [31:0] keycode = 32'h0000_002C;
    logic        point_p1 = 1'b0;
    logic        point_p2 = 1'b0;
    logic        ball_hold, run, serve_dir, winner;
    logic [7:0]  score1, score2;
    logic [1:0]  Display;

    int n_cmp = 0;
    int n_err = 0;

    match_sequencer #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .keycode(keycode),
        .point_p1(point_p1), .point_p2(point_p2), .ball_hold(ball_hold), .run(run),
        .serve_dir(serve_dir), .score1(score1), .score2(score2), .Display(Display),
        .winner(winner)
    );

    always #5 Clk = ~Clk;
    initial begin
        #2;
        forever #40 frame_vs = ~frame_vs;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model of the match rules ----------------
    int m_phase, m_ret, m_left, m_saved_left, m_pts1, m_pts2;
    bit m_dir, m_win;
    bit vh1, vh2, vh3;          // frame_vs seen at the last three clock edges
    bit s_prev, s_armed, p_prev, p_armed;

    function automatic bit has_key(input logic [31:0] kc, input logic [7:0] code);
        for (int b = 0; b < 4; b++)
            if (kc[8*b +: 8] == code) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd(input int n);
        int c;
        c = (n > 99) ? 99 : n;
        return (c / 10) * 16 + (c % 10);
    endfunction

    function automatic int exp_disp();
        if (m_phase == P_IDLE)  return 0;
        if (m_phase == P_OVER)  return 2;
        if (m_phase == P_PAUSE) return 3;
        return 1;
    endfunction

    function automatic int exp_hold();
        if (m_phase == P_RALLY) return 0;
        if (m_phase == P_PAUSE) return (m_ret == P_RALLY) ? 0 : 1;
        return 1;
    endfunction

    function automatic int exp_run();
        return (m_phase == P_SERVE || m_phase == P_RALLY) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_ret = P_IDLE; m_left = 0; m_saved_left = 0;
        m_pts1 = 0; m_pts2 = 0; m_dir = 1'b1; m_win = 1'b0;
        vh1 = 0; vh2 = 0; vh3 = 0;
        s_prev = 0; s_armed = 0; p_prev = 0; p_armed = 0;
    endtask

    task automatic model_step();
        bit tick, s_now, p_now, sp, pp;
        // a frame edge takes two synchroniser clocks before it acts
        tick  = vh2 && !vh3;
        s_now = has_key(keycode, 8'h2C);
        p_now = has_key(keycode, 8'h13);
        sp = s_now && !s_prev && s_armed;
        pp = PAUSE_EN && p_now && !p_prev && p_armed;
        vh3 = vh2; vh2 = vh1; vh1 = frame_vs;
        s_prev = s_now; if (!s_now) s_armed = 1;
        p_prev = p_now; if (!p_now) p_armed = 1;
        case (m_phase)
            P_IDLE, P_OVER: if (sp) begin
                m_dir  = (m_phase == P_IDLE) ? 1'b1 : !m_win;
                m_pts1 = 0; m_pts2 = 0;
                m_phase = P_SERVE; m_left = SF;
            end
            P_SERVE: if (pp) begin
                m_ret = P_SERVE; m_saved_left = m_left; m_phase = P_PAUSE;
            end else if (tick) begin
                m_left--;
                if (m_left == 0) m_phase = P_RALLY;
            end
            P_RALLY: if (point_p1 || point_p2) begin
                if (point_p1 && !point_p2) begin m_pts1++; m_dir = 1; end
                if (point_p2 && !point_p1) begin m_pts2++; m_dir = 0; end
                m_phase = P_POINT; m_left = PF;
            end else if (pp) begin
                m_ret = P_RALLY; m_saved_left = m_left; m_phase = P_PAUSE;
            end
            P_POINT: if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pts1 == WIN || m_pts2 == WIN) begin
                        m_phase = P_OVER; m_win = (m_pts1 != WIN);
                    end else begin
                        m_phase = P_SERVE; m_left = SF;
                    end
                end
            end
            P_PAUSE: if (pp) begin
                m_phase = m_ret; m_left = m_saved_left;
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) model_reset();
            else          model_step();
        end
    end

    // compare every output against the model on every falling clock edge
    initial begin
        forever begin
            @(negedge Clk);
            chk("Display",   Display,   exp_disp());
            chk("ball_hold", ball_hold, exp_hold());
            chk("run",       run,       exp_run());
            chk("serve_dir", serve_dir, m_dir);
            chk("score1",    score1,    bcd(m_pts1));
            chk("score2",    score2,    bcd(m_pts2));
            chk("winner",    winner,    m_win);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic at_frame_fall();
        @(negedge frame_vs);
    endtask

    task automatic press(input logic [31:0] kc);
        @(negedge Clk); keycode = kc;
        @(negedge Clk);
        @(negedge Clk); keycode = 32'h0;
    endtask

    task automatic pulse(input bit a, input bit b);
        @(negedge Clk); point_p1 = a; point_p2 = b;
        @(negedge Clk); point_p1 = 1'b0; point_p2 = 1'b0;
    endtask

    // count frame_vs rising edges until the outputs show the wanted state
    task automatic count_frames(input string name, input int d, input int h, input int r, output int n);
        bit last, now;
        n = 0;
        last = frame_vs;
        for (int c = 0; c < 20000; c++) begin
            @(negedge Clk);
            now = frame_vs;
            if (now && !last) n++;
            last = now;
            if (Display == d && ball_hold == h && run == r) return;
        end
        timeout(name);
        n = -1;
    endtask

    task automatic count_edges(input int want);
        bit last, now;
        int n;
        n = 0;
        last = frame_vs;
        while (n < want) begin
            @(negedge Clk);
            now = frame_vs;
            if (now && !last) n++;
            last = now;
        end
    endtask

    task automatic wait_rally();
        int n;
        count_frames("wait_rally", 1, 0, 1, n);
    endtask

    function automatic logic [31:0] rand_keys();
        logic [31:0] k;
        for (int b = 0; b < 4; b++) begin
            case ($urandom_range(0, 5))
                3:       k[8*b +: 8] = 8'h2C;
                4:       k[8*b +: 8] = 8'h13;
                5:       k[8*b +: 8] = 8'($urandom_range(0, 255));
                default: k[8*b +: 8] = 8'h00;
            endcase
        end
        return k;
    endfunction

    // ---------------- directed scenarios, then random ----------------
    initial begin
        int n;

        // reset with space already held
        repeat (3) @(negedge Clk);
        chk("rst_display", Display, 0);
        chk("rst_hold", ball_hold, 1);
        chk("rst_run", run, 0);
        chk("rst_dir", serve_dir, 1);
        chk("rst_score1", score1, 8'h00);
        @(negedge Clk); #3 Reset_n = 1'b1;
        repeat (20) @(negedge Clk);
        chk("held_key_idle", Display, 0);

        // release and re-press space: 60 frames of hold, then rally
        keycode = 32'h0;
        repeat (3) @(negedge Clk);
        at_frame_fall();
        press(32'h002C_0000);
        chk("start_serve", Display, 1);
        count_frames("serve_ticks", 1, 0, 1, n);
        chk("serve_hold_ticks", n, 60);

        // ten points to player 2, then one to player 1
        for (int i = 0; i < 10; i++) begin
            wait_rally();
            pulse(1'b0, 1'b1);
        end
        chk("p2_dir", serve_dir, 0);
        wait_rally();
        pulse(1'b1, 1'b0);
        chk("score2_10", score2, 8'h10);
        chk("score1_01", score1, 8'h01);
        chk("p1_dir", serve_dir, 1);

        // take player 1 to 10, then the winning point and 90-frame pause
        for (int i = 0; i < 9; i++) begin
            wait_rally();
            pulse(1'b1, 1'b0);
        end
        wait_rally();
        chk("score1_10", score1, 8'h10);
        at_frame_fall();
        pulse(1'b1, 1'b0);
        count_frames("point_ticks", 2, 1, 0, n);
        chk("point_ticks", n, 90);
        chk("over_winner", winner, 0);
        chk("over_score1", score1, 8'h11);

        // restart from game over
        at_frame_fall();
        press(32'h2C00_0000);
        chk("restart_score1", score1, 8'h00);
        chk("restart_score2", score2, 8'h00);
        chk("restart_display", Display, 1);
        chk("restart_dir", serve_dir, 1);

        // pause at 20 frames left in serve
        count_edges(40);
        at_frame_fall();
        press(32'h1300_0000);
`ifdef MATCH_PAUSE_EN
        count_edges(30);
        chk("pause_display", Display, 3);
        chk("pause_hold", ball_hold, 1);
        chk("pause_run", run, 0);
        at_frame_fall();
        press(32'h0000_1300);
`else
        chk("no_pause_display", Display, 1);
`endif
        count_frames("resume_ticks", 1, 0, 1, n);
        chk("serve_resume_ticks", n, 20);

        // simultaneous points replay; a point during serve is ignored
        pulse(1'b1, 1'b1);
        chk("replay_display", Display, 1);
        chk("replay_run", run, 0);
        chk("replay_score1", score1, 8'h00);
        chk("replay_score2", score2, 8'h00);
        count_frames("replay_serve", 1, 1, 1, n);
        pulse(1'b1, 1'b0);
        chk("serve_point_ignored", score1, 8'h00);

        // reset in the middle of a rally at 7-0
        for (int i = 0; i < 7; i++) begin
            wait_rally();
            pulse(1'b1, 1'b0);
        end
        wait_rally();
        chk("mid_score1", score1, 8'h07);
        @(posedge Clk); #2 Reset_n = 1'b0;
        #1;
        chk("async_display", Display, 0);
        chk("async_hold", ball_hold, 1);
        chk("async_run", run, 0);
        chk("async_dir", serve_dir, 1);
        chk("async_score1", score1, 8'h00);
        chk("async_score2", score2, 8'h00);
        chk("async_winner", winner, 0);
        repeat (3) @(negedge Clk);
        #3 Reset_n = 1'b1;

        // randomized keys, points and resets
        for (int c = 0; c < 8000; c++) begin
            @(negedge Clk);
            if ($urandom_range(0, 29) == 0) keycode = rand_keys();
            point_p1 = ($urandom_range(0, 59) == 0);
            point_p2 = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1999) == 0) begin
                @(posedge Clk); #2 Reset_n = 1'b0;
                repeat (3) @(negedge Clk);
                #3 Reset_n = 1'b1;
            end
        end
        @(negedge Clk);
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        repeat (2) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
